// File: rtl/latency_stamp_tx_if.sv
// ---------------------------------------------------------------------------
// latency_stamp_tx_if
// Packet stream between the latency stamp transmitter and its link.
//   CData : stamped test packet, {gray stamp, TX_Index, sequence number}
//   valid : CData carries a packet this cycle
//   ready : downstream accepts CData this cycle
// Modports: master = transmitter side, slave = link/receiver side.
// ---------------------------------------------------------------------------
interface latency_stamp_tx_if #(
    parameter int TIME_WIDTH  = 16,
    parameter int CDATA_WIDTH = 16
);
    logic [TIME_WIDTH+CDATA_WIDTH-1:0] CData;
    logic                              valid;
    logic                              ready;

    modport master (
        output CData,
        output valid,
        input  ready
    );

    modport slave (
        input  CData,
        input  valid,
        output ready
    );
endinterface

// File: rtl/latency_stamp_tx.sv
// ---------------------------------------------------------------------------
// latency_stamp_tx
// Transmit side of the per-link latency monitor. On a start request it
// launches pkt_num test packets, each stamped with the gray-coded global
// time at launch, separated by `interval` idle cycles, and pulses
// send_finish_flag once the burst is complete.
//
// Ports:
//   clk, rst          block clock, asynchronous active-high reset
//   TX_Index          source node index placed in every packet
//   start             one-cycle burst request (honoured only in IDLE)
//   pkt_num, interval burst length and inter-packet gap, latched on start
//   time_stamp        gray-coded global time (resynchronised by one flop)
//   tx (master)       CData / valid / ready packet stream
//   EN                burst in progress (SEND or GAP)
//   send_finish_flag  one-cycle end-of-burst pulse
//   sent_cnt          handshakes completed in the current burst
//   stall_sum         saturating count of valid && !ready cycles
//
// Build option:
//   TX_STALL_RESTAMP_EN  when defined, the stamp field is refreshed from the
//                        time flop on every backpressured cycle, so the
//                        measured latency excludes source-side stalls.
//                        When undefined the stamp is frozen at launch.
// ---------------------------------------------------------------------------
module latency_stamp_tx #(
    parameter int TIME_WIDTH  = 16,
    parameter int CDATA_WIDTH = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            TX_Index,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  pkt_num,
    input  logic [CNT_WIDTH-1:0]  interval,
    input  logic [TIME_WIDTH-1:0] time_stamp,
    latency_stamp_tx_if.master    tx,
    output logic                  EN,
    output logic                  send_finish_flag,
    output logic [CNT_WIDTH-1:0]  sent_cnt,
    output logic [CNT_WIDTH-1:0]  stall_sum
);

    localparam int DATA_W = TIME_WIDTH + CDATA_WIDTH;
    localparam int SEQ_W  = CDATA_WIDTH - 5;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [SEQ_W-1:0]     SEQ_ZERO = {SEQ_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  state_r;
    logic [TIME_WIDTH-1:0]   ts_r;
    logic [CNT_WIDTH-1:0]    pkt_num_r;
    logic [CNT_WIDTH-1:0]    interval_r;
    logic [CNT_WIDTH-1:0]    gap_cnt_r;
    logic [CNT_WIDTH-1:0]    sent_cnt_r;
    logic [CNT_WIDTH-1:0]    stall_sum_r;
    logic [DATA_W-1:0]       cdata_r;
    logic                    valid_r;
    logic                    en_r;
    logic                    finish_r;

    logic [CNT_WIDTH-1:0]    sent_inc_s;
    logic                    hs_s;
    logic                    stall_s;

    // Sequence number is the packet's position in the burst, wrapping at
    // the width of its field.
    function automatic logic [SEQ_W-1:0] seq_of(input logic [CNT_WIDTH-1:0] cnt);
        return SEQ_W'(cnt);
    endfunction

    // Assemble a packet: gray stamp on top, then source index, then sequence.
    function automatic logic [DATA_W-1:0] pack_pkt(
        input logic [TIME_WIDTH-1:0] stamp,
        input logic [4:0]            idx,
        input logic [SEQ_W-1:0]      seq
    );
        return {stamp, idx, seq};
    endfunction

    // Saturating increment so a long stall cannot wrap the statistic to 0.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : (v + CNT_ONE);
    endfunction

    assign sent_inc_s = sent_cnt_r + CNT_ONE;
    assign hs_s       = valid_r & tx.ready;
    assign stall_s    = valid_r & ~tx.ready;

    // Burst sequencer: time flop, FSM, packet register and statistics.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ts_r        <= {TIME_WIDTH{1'b0}};
            pkt_num_r   <= CNT_ZERO;
            interval_r  <= CNT_ZERO;
            gap_cnt_r   <= CNT_ZERO;
            sent_cnt_r  <= CNT_ZERO;
            stall_sum_r <= CNT_ZERO;
            cdata_r     <= {DATA_W{1'b0}};
            valid_r     <= 1'b0;
            en_r        <= 1'b0;
            finish_r    <= 1'b0;
        end else begin
            // The stamp is taken as gray code straight from this flop;
            // gray code changes one bit per tick, so a single flop suffices.
            ts_r     <= time_stamp;
            finish_r <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (pkt_num != CNT_ZERO) begin
                            pkt_num_r   <= pkt_num;
                            interval_r  <= interval;
                            sent_cnt_r  <= CNT_ZERO;
                            stall_sum_r <= CNT_ZERO;
                            cdata_r     <= pack_pkt(ts_r, TX_Index, SEQ_ZERO);
                            valid_r     <= 1'b1;
                            en_r        <= 1'b1;
                            state_r     <= ST_SEND;
                        end else begin
                            // Empty burst: report completion without sending.
                            finish_r <= 1'b1;
                            state_r  <= ST_DONE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_SEND: begin
                    if (stall_s) begin
                        stall_sum_r <= sat_inc(stall_sum_r);
                    end else begin
                        stall_sum_r <= stall_sum_r;
                    end

                    if (hs_s) begin
                        sent_cnt_r <= sent_inc_s;
                        if (sent_inc_s == pkt_num_r) begin
                            valid_r  <= 1'b0;
                            en_r     <= 1'b0;
                            finish_r <= 1'b1;
                            state_r  <= ST_DONE;
                        end else if (interval_r == CNT_ZERO) begin
                            // Back-to-back: next packet replaces the accepted one.
                            cdata_r <= pack_pkt(ts_r, TX_Index, seq_of(sent_inc_s));
                            state_r <= ST_SEND;
                        end else begin
                            valid_r   <= 1'b0;
                            gap_cnt_r <= interval_r;
                            state_r   <= ST_GAP;
                        end
                    end else begin
`ifdef TX_STALL_RESTAMP_EN
                        // Refresh only the stamp so source backpressure is
                        // not counted as link latency.
                        cdata_r[DATA_W-1:CDATA_WIDTH] <= ts_r;
`else
                        cdata_r <= cdata_r;
`endif
                        state_r <= ST_SEND;
                    end
                end

                ST_GAP: begin
                    // Launch on the last gap cycle so exactly `interval`
                    // cycles pass with valid low.
                    if (gap_cnt_r == CNT_ONE) begin
                        cdata_r <= pack_pkt(ts_r, TX_Index, seq_of(sent_cnt_r));
                        valid_r <= 1'b1;
                        state_r <= ST_SEND;
                    end else begin
                        gap_cnt_r <= gap_cnt_r - CNT_ONE;
                        state_r   <= ST_GAP;
                    end
                end

                ST_DONE: begin
                    state_r <= ST_IDLE;
                end

                default: begin
                    valid_r <= 1'b0;
                    en_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx.CData         = cdata_r;
    assign tx.valid         = valid_r;
    assign EN               = en_r;
    assign send_finish_flag = finish_r;
    assign sent_cnt         = sent_cnt_r;
    assign stall_sum        = stall_sum_r;

endmodule

// File: tb/tb_latency_stamp_tx.sv
// ---------------------------------------------------------------------------
// tb_latency_stamp_tx
// Self-checking bench for latency_stamp_tx built with CDATA_WIDTH=8 so the
// 3-bit sequence field wraps inside short bursts. Inputs are driven on the
// falling edge; outputs are sampled on the falling edge or #1 after the
// rising edge. Expected {TX_Index, seq} pairs are queued when a burst is
// requested and popped as each new packet appears on the bus.
// ---------------------------------------------------------------------------
module tb_latency_stamp_tx;

    localparam int TW = 16;
    localparam int CW = 8;
    localparam int NW = 16;

    logic          clk;
    logic          rst;
    logic [4:0]    TX_Index;
    logic          start;
    logic [NW-1:0] pkt_num;
    logic [NW-1:0] interval;
    logic [TW-1:0] time_stamp;
    logic          EN;
    logic          send_finish_flag;
    logic [NW-1:0] sent_cnt;
    logic [NW-1:0] stall_sum;

    latency_stamp_tx_if #(.TIME_WIDTH(TW), .CDATA_WIDTH(CW)) tx_if ();

    latency_stamp_tx #(.TIME_WIDTH(TW), .CDATA_WIDTH(CW), .CNT_WIDTH(NW)) dut (
        .clk              (clk),
        .rst              (rst),
        .TX_Index         (TX_Index),
        .start            (start),
        .pkt_num          (pkt_num),
        .interval         (interval),
        .time_stamp       (time_stamp),
        .tx               (tx_if),
        .EN               (EN),
        .send_finish_flag (send_finish_flag),
        .sent_cnt         (sent_cnt),
        .stall_sum        (stall_sum)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          fin_cnt = 0;
    logic [7:0]  sb_q[$];
    logic [15:0] tcnt;
    logic        prev_valid;
    logic [7:0]  cur_meta;
    logic [15:0] cur_stamp;

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction

    // Free-running global time, presented gray-coded, advanced on falling edges.
    initial begin
        tcnt       = 16'd0;
        time_stamp = gray(16'd0);
        forever begin
            @(negedge clk);
            tcnt       = tcnt + 16'd1;
            time_stamp = gray(tcnt);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_burst(input logic [4:0] idx, input int n, input int gap);
        logic [2:0] s_v;
        TX_Index = idx;
        pkt_num  = 16'(n);
        interval = 16'(gap);
        start    = 1'b1;
        for (int i = 0; i < n; i++) begin
            s_v = 3'(i);
            sb_q.push_back({idx, s_v});
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_finish(input int lim, input string tag);
        for (int i = 0; i < lim && !send_finish_flag; i++) tick();
        check_val(tag, 32'(send_finish_flag), 32'd1);
    endtask

    // Packet monitor: a packet is new when valid was low before or the
    // previous packet was accepted at the edge just taken.
    initial prev_valid = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (tx_if.valid) begin
                if (!prev_valid || tx_if.ready) begin
                    if (sb_q.size() == 0) begin
                        check_val("unexpected_pkt", 32'(tx_if.CData), 32'hFFFF_FFFF);
                    end else begin
                        cur_meta = sb_q.pop_front();
                    end
                    cur_stamp = gray(tcnt - 16'd1);
                end else begin
`ifdef TX_STALL_RESTAMP_EN
                    cur_stamp = gray(tcnt - 16'd1);
`endif
                end
                check_val("pkt_stamp", 32'(tx_if.CData[TW+CW-1:CW]), 32'(cur_stamp));
                check_val("pkt_meta",  32'(tx_if.CData[CW-1:0]),     32'(cur_meta));
            end
            if (send_finish_flag) fin_cnt++;
            prev_valid = tx_if.valid;
        end
    end

    // Directed sequence.
    initial begin
        int f0;
        rst         = 1'b1;
        start       = 1'b0;
        tx_if.ready = 1'b1;
        TX_Index    = 5'd0;
        pkt_num     = 16'd0;
        interval    = 16'd0;
        repeat (3) tick();
        check_val("rst_valid",  32'(tx_if.valid),      32'd0);
        check_val("rst_en",     32'(EN),               32'd0);
        check_val("rst_cdata",  32'(tx_if.CData),      32'd0);
        check_val("rst_sent",   32'(sent_cnt),         32'd0);
        check_val("rst_stall",  32'(stall_sum),        32'd0);
        check_val("rst_finish", 32'(send_finish_flag), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Back-to-back burst of 4.
        start_burst(5'd3, 4, 0);
        for (int i = 0; i < 4; i++) begin
            check_val("t1_valid", 32'(tx_if.valid), 32'd1);
            tick();
        end
        check_val("t1_finish", 32'(send_finish_flag), 32'd1);
        check_val("t1_valid_off", 32'(tx_if.valid), 32'd0);
        check_val("t1_en_off", 32'(EN), 32'd0);
        check_val("t1_sent", 32'(sent_cnt), 32'd4);
        check_val("t1_stall", 32'(stall_sum), 32'd0);
        tick();
        check_val("t1_finish_once", 32'(send_finish_flag), 32'd0);
        check_val("t1_sent_hold", 32'(sent_cnt), 32'd4);

        // 3 packets with 5-cycle gaps; a stray start mid-burst must be ignored.
        start_burst(5'd10, 3, 5);
        for (int i = 1; i <= 13; i++) begin
            check_val("t2_en", 32'(EN), 32'd1);
            check_val("t2_valid", 32'(tx_if.valid), (i == 1 || i == 7 || i == 13) ? 32'd1 : 32'd0);
            if (i == 3) begin
                start   = 1'b1;
                pkt_num = 16'd9;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check_val("t2_finish", 32'(send_finish_flag), 32'd1);
        check_val("t2_en_off", 32'(EN), 32'd0);
        check_val("t2_sent", 32'(sent_cnt), 32'd3);
        tick();

        // First packet backpressured for 7 cycles.
        tx_if.ready = 1'b0;
        start_burst(5'd31, 2, 0);
        repeat (7) tick();
        tx_if.ready = 1'b1;
        wait_finish(20, "t3_finish");
        check_val("t3_sent", 32'(sent_cnt), 32'd2);
        check_val("t3_stall", 32'(stall_sum), 32'd7);
        tick();

        // Empty burst.
        start_burst(5'd0, 0, 0);
        check_val("t4_finish", 32'(send_finish_flag), 32'd1);
        check_val("t4_valid", 32'(tx_if.valid), 32'd0);
        check_val("t4_en", 32'(EN), 32'd0);
        tick();
        check_val("t4_finish_once", 32'(send_finish_flag), 32'd0);
        check_val("t4_en_after", 32'(EN), 32'd0);

        // Asynchronous reset mid-burst after 2 of 5 packets.
        start_burst(5'd7, 5, 0);
        tick();
        tick();
        check_val("t5_sent_pre", 32'(sent_cnt), 32'd2);
        check_val("t5_valid_pre", 32'(tx_if.valid), 32'd1);
        f0 = fin_cnt;
        rst = 1'b1;
        #1;
        check_val("t5_valid", 32'(tx_if.valid), 32'd0);
        check_val("t5_en", 32'(EN), 32'd0);
        check_val("t5_cdata", 32'(tx_if.CData), 32'd0);
        check_val("t5_sent", 32'(sent_cnt), 32'd0);
        sb_q.delete();
        repeat (2) tick();
        check_val("t5_finish_rst", 32'(send_finish_flag), 32'd0);
        rst = 1'b0;
        repeat (2) tick();
        check_val("t5_no_finish", 32'(fin_cnt), 32'(f0));
        start_burst(5'd7, 1, 0);
        wait_finish(10, "t5_finish");
        check_val("t5_sent_after", 32'(sent_cnt), 32'd1);
        tick();

        // Long burst: sequence wraps every 8 packets, index 19 on each.
        start_burst(5'd19, 40, 2);
        wait_finish(400, "t6_finish");
        check_val("t6_sent", 32'(sent_cnt), 32'd40);
        check_val("t6_stall", 32'(stall_sum), 32'd0);
        tick();

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/latency_stamp_tx.md
Name: latency_stamp_tx

Overview:
- Transmit-side companion of the per-link latency monitor.
- Launches a programmed burst of test packets onto CData and stamps each one with the gray-coded global time at launch.
- The receiving monitor subtracts this stamp from its own time to measure latency.
- Owns the packet-count/interval sequencing, the valid/ready handshake and the end-of-burst flag.

Parameters:
- TIME_WIDTH, 16, width of the gray-coded global time stamp and of the stamp field in CData.
- CDATA_WIDTH, 16, payload field width; must be >= 8.
- CNT_WIDTH, 16, width of the packet count, interval and statistics counters.

Ports:
- clk  in  1  single block clock.
- rst  in  1  asynchronous, active-high reset.
- TX_Index  in  5  source node index, placed in the payload.
- start  in  1  one-cycle burst request; sampled only in IDLE.
- pkt_num  in  CNT_WIDTH  packets in the burst; latched on start.
- interval  in  CNT_WIDTH  idle cycles between a handshake and the next launch; latched on start.
- time_stamp  in  TIME_WIDTH  gray-coded global time.
- ready  in  1  downstream accepts CData this cycle.
- CData  out  TIME_WIDTH+CDATA_WIDTH  packet. Fields: [TIME_WIDTH+CDATA_WIDTH-1:CDATA_WIDTH] gray stamp; [CDATA_WIDTH-1:CDATA_WIDTH-5] TX_Index; [CDATA_WIDTH-6:0] sequence number.
- valid  out  1  CData valid.
- EN  out  1  burst in progress; drives the receiver's EN.
- send_finish_flag  out  1  one-cycle end-of-burst pulse.
- sent_cnt  out  CNT_WIDTH  handshakes completed in the current burst.
- stall_sum  out  CNT_WIDTH  cycles with valid && !ready in the current burst; saturating.

Behaviour:
- Reset: while rst=1, all registers and outputs are 0 and the FSM is in IDLE.
  - Reset is asynchronous and takes effect immediately, including mid-burst. No packet is completed and send_finish_flag is not pulsed.
- ts_reg <= time_stamp every cycle; this is one synchronising flop. The stamp is always copied from ts_reg as gray code with no conversion.
- FSM states: IDLE, SEND, GAP, DONE.
  - IDLE, start=1, pkt_num!=0: latch pkt_num and interval, clear sent_cnt and stall_sum, go to SEND.
  - At that same edge, load CData with stamp=ts_reg and seq=0, and set valid=1. Valid therefore rises 1 cycle after start.
  - IDLE, start=1, pkt_num==0: go to DONE; no packet is sent.
  - SEND: valid=1 and CData is held stable until ready=1.
    - On handshake (valid && ready), sent_cnt increments.
    - If the new sent_cnt equals latched pkt_num, go to DONE and drop valid.
    - Else if interval==0, stay in SEND and load the next packet at the same edge (back-to-back).
    - Else go to GAP with gap_cnt=interval and drop valid.
  - GAP: valid=0 and gap_cnt decrements each cycle. When gap_cnt==1, go to SEND and load the next packet (stamp=ts_reg, seq=sent_cnt). A nonzero interval therefore gives exactly interval cycles with valid=0.
  - DONE: send_finish_flag=1 for exactly this cycle, then go to IDLE.
- EN=1 in SEND and GAP, 0 otherwise.
- ready is ignored while valid=0. start is ignored outside IDLE.
- The sequence number is sent_cnt at load, truncated to CDATA_WIDTH-5 bits and wrapping modulo 2^(CDATA_WIDTH-5).
- stall_sum increments each cycle with valid && !ready and holds at all-ones.
- sent_cnt and stall_sum hold their values after DONE until the next accepted start.
- The stamp wraps naturally with the global gray counter; wrap handling is the receiver's job.
- CData holds its last value while valid=0.

Optional Feature:
- Macro: TX_STALL_RESTAMP_EN.
- Defined: while valid && !ready, the stamp field is reloaded from ts_reg every cycle, so measured latency excludes source backpressure. TX_Index and seq stay stable. stall_sum is still counted.
- Undefined: the stamp is frozen at load, and backpressure time counts as latency.

Test Plan:
- pkt_num=4, interval=0, ready tied 1, time_stamp = gray of a free-running counter → valid high for 4 consecutive cycles starting 1 cycle after start; seq 0..3; each stamp = gray(counter) at load minus 1 cycle; send_finish_flag pulses 1 cycle after the last handshake; sent_cnt=4; stall_sum=0.
- pkt_num=3, interval=5, ready=1 → exactly 5 valid-low cycles between handshakes; EN=1 throughout the gaps; burst spans 13 cycles from first valid to last handshake.
- pkt_num=2, interval=0, ready low for 7 cycles on the first packet → CData held stable for 7 cycles (stamp frozen without the macro, advancing with it); stall_sum=7; sent_cnt=2.
- start with pkt_num=0 → no valid; send_finish_flag pulses 1 cycle after start; EN stays 0.
- rst=1 mid-burst after 2 of 5 packets with valid high → valid, EN, CData, sent_cnt drop to 0 immediately; no finish pulse. After release, start with pkt_num=1 sends seq 0.
- pkt_num=40, CDATA_WIDTH=8 → seq wraps 7→0 after every 8 packets; TX_Index=5'd19 appears in CData[7:3] on every packet.
